bt_mode_ctrl: RTL and testbench

//  Downstream consumer of the Bluetooth UART command decoder. Turns its sticky one-hot choose[3:0]
//  ('A'=0001,'B'=0010,'C'=0100,'D'=1000) into the piano-game mode FSM (free play, song demo,

---
 rtl/bt_mode_pkg.sv | 29 ++
 rtl/sec_tick_gen.sv | 27 ++
 rtl/bt_mode_ctrl.sv | 142 ++++++++++++++
 tb/tb_bt_mode_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bt_mode_pkg.sv
// Shared state codes and command letters for the piano-game mode controller.
package bt_mode_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FREE  = 3'd1;
  localparam logic [2:0] SONG  = 3'd2;
  localparam logic [2:0] CNTDN = 3'd3;
  localparam logic [2:0] GAME  = 3'd4;

  localparam logic [3:0] CMD_A = 4'b0001;
  localparam logic [3:0] CMD_B = 4'b0010;
  localparam logic [3:0] CMD_C = 4'b0100;
  localparam logic [3:0] CMD_D = 4'b1000;

  // Maps a command letter to its target state; non-letters keep the current state.
  function automatic logic [2:0] cmd_target(input logic [3:0] cmd, input logic [2:0] cur);
    logic [2:0] t;
    t = cur;
    case (cmd)
      CMD_A:   t = FREE;
      CMD_B:   t = SONG;
      CMD_C:   t = CNTDN;
      CMD_D:   t = IDLE;
      default: t = cur;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick generator: counts enabled cycles, pulses tick on the last count and wraps.
module sec_tick_gen #(
  parameter int unsigned TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bt_mode_ctrl.sv
// Piano-game mode FSM driven by the Bluetooth command decoder's sticky one-hot letter.
module bt_mode_ctrl
  import bt_mode_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned COUNTDOWN_S = 3,
  parameter int unsigned GAME_S      = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] choose,
  input  logic       song_done,
  input  logic       game_over,
  output logic [2:0] mode,
  output logic       start_p,
  output logic       stop_p,
  output logic [1:0] countdown,
  output logic [7:0] sec_left,
  output logic       busy
);

  localparam logic [1:0] CD_INIT  = 2'(COUNTDOWN_S);
  localparam logic [7:0] SEC_INIT = 8'(GAME_S);

  logic [3:0] choose_q, cmd_q;
  logic       evt_q;
  logic [2:0] state_q, state_d, target;
  logic       start_q, start_d, stop_q, stop_d;
  logic [1:0] cd_q, cd_d;
  logic [7:0] sec_q, sec_d;
  logic       busy_q;
  logic       tick, tick_en, tick_clr;

  // Edge stage: a new one-hot letter becomes a registered event one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      choose_q <= '0;
      cmd_q    <= '0;
      evt_q    <= 1'b0;
    end else begin
      choose_q <= choose;
      cmd_q    <= choose;
      evt_q    <= (choose != choose_q) && $onehot(choose);
    end
  end

  assign tick_en  = (state_q == CNTDN) || (state_q == GAME);
  assign tick_clr = (state_d != state_q);

  sec_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .en  (tick_en),
    .tick(tick)
  );

  assign target = cmd_target(cmd_q, state_q);

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    cd_d    = cd_q;
    sec_d   = sec_q;
    if (evt_q && (target != state_q)) begin
      state_d = target;
      stop_d  = (state_q != IDLE);
      start_d = (target == FREE) || (target == SONG);
      cd_d    = '0;
      if (target == CNTDN) begin
        cd_d  = CD_INIT;
        sec_d = '0;
      end
    end else begin
      case (state_q)
        SONG: begin
          if (song_done) begin
            state_d = IDLE;
            stop_d  = 1'b1;
          end
        end
        CNTDN: begin
          if (tick) begin
            if (cd_q == 2'd1) begin
              state_d = GAME;
              cd_d    = '0;
              sec_d   = SEC_INIT;
              start_d = 1'b1;
            end else if (cd_q != '0) begin
              cd_d = cd_q - 2'd1;
            end
          end
        end
        GAME: begin
          // sec_left is left untouched on game_over so the score display keeps it.
          if (game_over) begin
            state_d = IDLE;
            stop_d  = 1'b1;
          end else if (tick) begin
            if (sec_q == 8'd1) begin
              sec_d   = '0;
              state_d = IDLE;
              stop_d  = 1'b1;
            end else if (sec_q != '0) begin
              sec_d = sec_q - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      cd_q    <= '0;
      sec_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      cd_q    <= cd_d;
      sec_q   <= sec_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign mode      = state_q;
  assign start_p   = start_q;
  assign stop_p    = stop_q;
  assign countdown = cd_q;
  assign sec_left  = sec_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bt_mode_ctrl.sv
// Bench for bt_mode_ctrl: command table plus timed sequences, checked through an expectation queue.
module tb_bt_mode_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] choose;
  logic       song_done;
  logic       game_over;
  logic [2:0] mode;
  logic       start_p;
  logic       stop_p;
  logic [1:0] countdown;
  logic [7:0] sec_left;
  logic       busy;

  bt_mode_ctrl #(
    .TICK_CYCLES(10),
    .COUNTDOWN_S(3),
    .GAME_S     (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .choose   (choose),
    .song_done(song_done),
    .game_over(game_over),
    .mode     (mode),
    .start_p  (start_p),
    .stop_p   (stop_p),
    .countdown(countdown),
    .sec_left (sec_left),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      name;
    logic [2:0] mode;
    logic       start;
    logic       stop;
    logic [1:0] cd;
    logic [7:0] sec;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [3:0] choose;
    logic [2:0] mode;
    logic       start;
    logic       stop;
    logic [1:0] cd;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.due != cyc) begin
        $display("FAIL %s: check missed, due cycle %0d, now %0d", e.name, e.due, cyc);
      end else if (mode !== e.mode || start_p !== e.start || stop_p !== e.stop ||
                   countdown !== e.cd || sec_left !== e.sec || busy !== e.busy) begin
        $display("FAIL %s @%0d: got mode=%0d start=%0b stop=%0b cd=%0d sec=%0d busy=%0b, want mode=%0d start=%0b stop=%0b cd=%0d sec=%0d busy=%0b",
                 e.name, cyc, mode, start_p, stop_p, countdown, sec_left, busy,
                 e.mode, e.start, e.stop, e.cd, e.sec, e.busy);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic exp_at(input int dly, input string nm, input logic [2:0] m, input logic st,
                        input logic sp, input logic [1:0] c, input logic [7:0] s);
    exp_t e;
    e.due = cyc + dly; e.name = nm; e.mode = m; e.start = st; e.stop = sp;
    e.cd = c; e.sec = s; e.busy = (m != 3'd0);
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b0001, 3'd1, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{4'b0010, 3'd2, 1'b1, 1'b1, 2'd0};
    tbl[2] = '{4'b0011, 3'd2, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{4'b0000, 3'd2, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{4'b0010, 3'd2, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{4'b1000, 3'd0, 1'b0, 1'b1, 2'd0};
    tbl[6] = '{4'b0100, 3'd3, 1'b0, 1'b0, 2'd3};
    tbl[7] = '{4'b0001, 3'd1, 1'b1, 1'b1, 2'd0};
    tbl[8] = '{4'b1000, 3'd0, 1'b0, 1'b1, 2'd0};

    rst = 1'b1; choose = 4'b0001; song_done = 1'b0; game_over = 1'b0;
    step(3);

    // Reset with 'A' held: FREE two edges after release, single start pulse.
    exp_at(0, "reset", 3'd0, 0, 0, 2'd0, 8'd0);
    rst = 1'b0;
    exp_at(1, "rel_idle", 3'd0, 0, 0, 2'd0, 8'd0);
    exp_at(2, "rel_free", 3'd1, 1, 0, 2'd0, 8'd0);
    exp_at(3, "rel_free_hold", 3'd1, 0, 0, 2'd0, 8'd0);
    step(4);
    choose = 4'b1000;
    exp_at(2, "d_idle", 3'd0, 0, 1, 2'd0, 8'd0);
    exp_at(3, "d_idle_hold", 3'd0, 0, 0, 2'd0, 8'd0);
    step(4);

    for (int i = 0; i < 9; i++) begin
      choose = tbl[i].choose;
      exp_at(2, $sformatf("tbl%0d", i), tbl[i].mode, tbl[i].start, tbl[i].stop, tbl[i].cd, 8'd0);
      exp_at(3, $sformatf("tbl%0d_hold", i), tbl[i].mode, 1'b0, 1'b0, tbl[i].cd, 8'd0);
      step(4);
    end

    // Full countdown and game run to expiry.
    choose = 4'b0000;
    step(2);
    choose = 4'b0100;
    exp_at(2,  "cd_enter", 3'd3, 0, 0, 2'd3, 8'd0);
    exp_at(11, "cd_3_last", 3'd3, 0, 0, 2'd3, 8'd0);
    exp_at(12, "cd_2", 3'd3, 0, 0, 2'd2, 8'd0);
    exp_at(22, "cd_1", 3'd3, 0, 0, 2'd1, 8'd0);
    exp_at(31, "cd_1_last", 3'd3, 0, 0, 2'd1, 8'd0);
    exp_at(32, "game_enter", 3'd4, 1, 0, 2'd0, 8'd5);
    exp_at(33, "game_hold", 3'd4, 0, 0, 2'd0, 8'd5);
    exp_at(42, "game_4", 3'd4, 0, 0, 2'd0, 8'd4);
    exp_at(81, "game_1_last", 3'd4, 0, 0, 2'd0, 8'd1);
    exp_at(82, "game_expire", 3'd0, 0, 1, 2'd0, 8'd0);
    exp_at(83, "game_expire_hold", 3'd0, 0, 0, 2'd0, 8'd0);
    step(86);

    // game_over freezes sec_left; song_done in IDLE is ignored.
    choose = 4'b1000;
    step(2);
    choose = 4'b0100;
    exp_at(52, "go_sec3", 3'd4, 0, 0, 2'd0, 8'd3);
    step(57);
    game_over = 1'b1;
    exp_at(1, "go_idle", 3'd0, 0, 1, 2'd0, 8'd3);
    exp_at(2, "go_idle_hold", 3'd0, 0, 0, 2'd0, 8'd3);
    step(1);
    game_over = 1'b0;
    step(2);
    song_done = 1'b1;
    exp_at(2, "sd_in_idle", 3'd0, 0, 0, 2'd0, 8'd3);
    step(1);
    song_done = 1'b0;
    step(3);

    // FREE -> SONG gives start and stop together; song_done ends the demo.
    choose = 4'b0001;
    exp_at(2, "free2", 3'd1, 1, 0, 2'd0, 8'd3);
    step(4);
    choose = 4'b0010;
    exp_at(2, "free_to_song", 3'd2, 1, 1, 2'd0, 8'd3);
    exp_at(3, "song_hold", 3'd2, 0, 0, 2'd0, 8'd3);
    step(4);
    song_done = 1'b1;
    exp_at(1, "song_done", 3'd0, 0, 1, 2'd0, 8'd3);
    exp_at(2, "song_done_hold", 3'd0, 0, 0, 2'd0, 8'd3);
    step(1);
    song_done = 1'b0;
    step(3);

    // Command, game_over and final tick land on the same FSM edge: command wins.
    choose = 4'b0100;
    exp_at(2, "cd_enter2", 3'd3, 0, 0, 2'd3, 8'd0);
    exp_at(81, "sim_pre", 3'd4, 0, 0, 2'd0, 8'd1);
    step(80);
    choose = 4'b0001;
    step(1);
    game_over = 1'b1;
    exp_at(1, "sim_free", 3'd1, 1, 1, 2'd0, 8'd1);
    exp_at(2, "sim_free_hold", 3'd1, 0, 0, 2'd0, 8'd1);
    step(1);
    game_over = 1'b0;
    step(3);

    // Reset in the middle of a countdown: IDLE with no stop pulse.
    choose = 4'b0100;
    exp_at(2, "cd_from_free", 3'd3, 0, 1, 2'd3, 8'd0);
    step(17);
    rst = 1'b1;
    choose = 4'b0000;
    exp_at(1, "mid_rst", 3'd0, 0, 0, 2'd0, 8'd0);
    exp_at(2, "mid_rst_hold", 3'd0, 0, 0, 2'd0, 8'd0);
    step(2);
    rst = 1'b0;
    exp_at(3, "post_rst", 3'd0, 0, 0, 2'd0, 8'd0);
    step(5);

    if (sb.size() != 0) begin
      $display("FAIL drain: %0d checks never reached, want 0", sb.size());
      n_checks += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
